bcd2bin_seq: RTL and testbench

//  Sequential 4-digit BCD-to-binary converter (reverse double-dabble); the decode direction
//  for the bin-to-BCD path feeding seven_seg_mux. Converts switch-entered BCD operands to

---
 rtl/bcd2bin_seq.sv | 123 ++++++++++++
 tb/tb_bcd2bin_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential 4-digit BCD-to-binary converter using reverse double-dabble.
// Each clock performs one shift/correct step; start/ready/done_tick handshake.
module bcd2bin_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_bcd3,
  input  logic [3:0]  i_bcd2,
  input  logic [3:0]  i_bcd1,
  input  logic [3:0]  i_bcd0,
  output logic        o_ready,
  output logic        o_done_tick,
  output logic [13:0] o_bin,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OP   = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  logic [15:0] bcd_r;
  logic [13:0] bin_r;
  logic [3:0]  n_r;

  logic [15:0] bcd_shift_s;
  logic [15:0] bcd_next_s;
  logic [13:0] bin_next_s;
  logic        digits_ok_s;

  // A shifted digit that was odd picked up 8 from the digit above; taking 3 off
  // turns that borrowed "10" back into the 5 it is worth after halving.
  function automatic logic [3:0] dabble_down(input logic [3:0] d);
    if (d >= 4'd8) begin
      return d - 4'd3;
    end else begin
      return d;
    end
  endfunction

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Next-step datapath: shift the {bcd,bin} pair right, then correct each digit.
  always_comb begin
    bcd_shift_s = {1'b0, bcd_r[15:1]};
    bin_next_s  = {bcd_r[0], bin_r[13:1]};
    bcd_next_s  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      bcd_next_s[4*i +: 4] = dabble_down(bcd_shift_s[4*i +: 4]);
    end
    digits_ok_s = digit_ok(i_bcd3) && digit_ok(i_bcd2) &&
                  digit_ok(i_bcd1) && digit_ok(i_bcd0);
  end

  // Control FSM and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= IDLE;
      bcd_r       <= 16'h0000;
      bin_r       <= 14'd0;
      n_r         <= 4'd0;
      o_ready     <= 1'b1;
      o_done_tick <= 1'b0;
      o_bin       <= 14'd0;
      o_err       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          o_done_tick <= 1'b0;
          if (i_start) begin
            o_ready <= 1'b0;
            if (digits_ok_s) begin
              bcd_r   <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
              bin_r   <= 14'd0;
              n_r     <= 4'd13;
              state_r <= OP;
            end else begin
              // Bad digit: report straight away without spending OP cycles.
              bcd_r       <= 16'h0000;
              bin_r       <= 14'd0;
              n_r         <= 4'd0;
              o_bin       <= 14'd0;
              o_err       <= 1'b1;
              o_done_tick <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        OP: begin
          bcd_r   <= bcd_next_s;
          bin_r   <= bin_next_s;
          o_ready <= 1'b0;
          if (n_r == 4'd0) begin
            o_bin       <= bin_next_s;
            o_err       <= 1'b0;
            o_done_tick <= 1'b1;
            state_r     <= DONE;
          end else begin
            n_r         <= n_r - 4'd1;
            o_done_tick <= 1'b0;
          end
        end
        DONE: begin
          o_done_tick <= 1'b0;
          o_ready     <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          o_done_tick <= 1'b0;
          o_ready     <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed-vector bench for bcd2bin_seq: latency, values, error path, abort, back-to-back.
module tb_bcd2bin_seq;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [3:0]  i_bcd3;
  logic [3:0]  i_bcd2;
  logic [3:0]  i_bcd1;
  logic [3:0]  i_bcd0;
  logic        o_ready;
  logic        o_done_tick;
  logic [13:0] o_bin;
  logic        o_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bcd2bin_seq dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_bcd3      (i_bcd3),
    .i_bcd2      (i_bcd2),
    .i_bcd1      (i_bcd1),
    .i_bcd0      (i_bcd0),
    .o_ready     (o_ready),
    .o_done_tick (o_done_tick),
    .o_bin       (o_bin),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then return at the negedge where done_tick is seen.
  // lat = number of rising edges from the start edge (counted as 1) to the first
  // edge that observes done_tick high.
  task automatic run(input logic [3:0] d3, input logic [3:0] d2,
                     input logic [3:0] d1, input logic [3:0] d0,
                     input bit disturb, output int lat);
    @(negedge i_clk);
    i_bcd3 = d3; i_bcd2 = d2; i_bcd1 = d1; i_bcd0 = d0;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_done_tick && lat < 40) begin
      if (disturb) begin
        check("t4_ready_low_op", o_ready, 0);
        if (lat == 5) begin
          i_start = 1'b1;
          i_bcd3 = 4'd9; i_bcd2 = 4'd9; i_bcd1 = 4'd9; i_bcd0 = 4'd9;
        end
        if (lat == 6) i_start = 1'b0;
      end
      @(negedge i_clk);
      lat++;
    end
    check("done_ready_low", o_ready, 0);
  endtask

  int lat;
  int t1;
  int t2;
  int k;
  int ticks;

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_bcd3 = 4'd0; i_bcd2 = 4'd0; i_bcd1 = 4'd0; i_bcd0 = 4'd0;
    #12;
    check("rst_ready", o_ready, 1);
    check("rst_done", o_done_tick, 0);
    check("rst_bin", o_bin, 0);
    check("rst_err", o_err, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // 1: max value, latency
    run(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, lat);
    check("t1_lat", lat, 15);
    check("t1_bin", o_bin, 14'h270F);
    check("t1_err", o_err, 0);
    @(negedge i_clk);
    check("t1_ready_back", o_ready, 1);
    check("t1_done_one_cycle", o_done_tick, 0);
    check("t1_bin_hold", o_bin, 9999);

    // 2: zero and small value
    run(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, lat);
    check("t2_zero_bin", o_bin, 0);
    check("t2_zero_err", o_err, 0);
    run(4'd0, 4'd0, 4'd9, 4'd3, 1'b0, lat);
    check("t2_93_bin", o_bin, 93);

    // 3: invalid digit, then recovery
    run(4'd0, 4'd0, 4'hA, 4'd5, 1'b0, lat);
    check("t3_bad_lat", lat, 1);
    check("t3_bad_bin", o_bin, 0);
    check("t3_bad_err", o_err, 1);
    @(negedge i_clk);
    check("t3_err_hold", o_err, 1);
    run(4'hF, 4'd0, 4'd0, 4'd0, 1'b0, lat);
    check("t3_bad_thousands_err", o_err, 1);
    run(4'd0, 4'd0, 4'd1, 4'd2, 1'b0, lat);
    check("t3_ok_err", o_err, 0);
    check("t3_ok_bin", o_bin, 12);
    check("t3_ok_lat", lat, 15);

    // 4: start pulse and digit changes during OP are ignored
    run(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, lat);
    check("t4_lat", lat, 15);
    check("t4_bin", o_bin, 1234);
    @(negedge i_clk);
    check("t4_ready_back", o_ready, 1);

    // 5: reset mid-OP aborts with no done_tick
    @(negedge i_clk);
    i_bcd3 = 4'd5; i_bcd2 = 4'd6; i_bcd1 = 4'd7; i_bcd0 = 4'd8;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("t5_ready", o_ready, 1);
    check("t5_done", o_done_tick, 0);
    check("t5_bin", o_bin, 0);
    check("t5_err", o_err, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_done_tick) ticks++;
    end
    check("t5_no_done", ticks, 0);
    run(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, lat);
    check("t5_after_bin", o_bin, 42);

    // Sampled sweep against a decimal reference
    for (int v = 0; v < 10000; v += 101) begin
      run(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), 1'b0, lat);
      check("sweep_bin", o_bin, v);
    end
    run(4'd9, 4'd0, 4'd0, 4'd8, 1'b0, lat);
    check("sweep_9008", o_bin, 9008);

    // 6: start held high gives one conversion every 16 cycles
    @(negedge i_clk);
    i_bcd3 = 4'd0; i_bcd2 = 4'd0; i_bcd1 = 4'd0; i_bcd0 = 4'd1;
    i_start = 1'b1;
    k = 0;
    while (!o_done_tick && k < 40) begin
      @(negedge i_clk);
      k++;
    end
    t1 = cyc;
    check("t6_first_bin", o_bin, 1);
    i_bcd0 = 4'd2;
    @(negedge i_clk);
    k = 0;
    while (!o_done_tick && k < 40) begin
      @(negedge i_clk);
      k++;
    end
    t2 = cyc;
    i_start = 1'b0;
    check("t6_period", t2 - t1, 16);
    check("t6_second_bin", o_bin, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
